muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Sequences the iterative multiplier and divider that feed the HI/LO registers of the multicycle CPU.
- Accepts one-cycle start pulses from the main control FSM and generates the load and step strobes for the selected unit.
- Counts the iterations, then issues the HI/LO write strobes and the HI/LO source select.
- Detects divide-by-zero before starting a division and flags it instead of running the divider.

Parameters:
- MULT_CYCLES, 32, number of step cycles the multiplier needs.
- DIV_CYCLES, 32, number of step cycles the divider needs.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- mult_start  input  1  one-cycle request to run a multiply.
- div_start  input  1  one-cycle request to run a divide.
- divisor_zero  input  1  high when the B operand equals 0; sampled with div_start.
- mult_load  output  1  loads the multiplier operands.
- mult_step  output  1  advances the multiplier by one iteration.
- div_load  output  1  loads the divider operands.
- div_step  output  1  advances the divider by one iteration.
- HiLoSrc  output  1  HI/LO input select: 0 = multiplier, 1 = divider.
- HI_write  output  1  write strobe for the HI register.
- LO_write  output  1  write strobe for the LO register.
- busy  output  1  high while an operation is in progress; control FSM waits on it.
- done  output  1  one-cycle pulse when a result has been written.
- div0_exc  output  1  one-cycle divide-by-zero pulse.

Behaviour:
- Outputs are registered or decoded from the state register. Reset, sampled on the posedge of clk, forces state IDLE, counter 0 and every output 0.
- States: IDLE, M_LOAD, M_RUN, D_LOAD, D_RUN, WRITE, EXC.
- IDLE transitions:
  - mult_start=1 → M_LOAD.
  - div_start=1 and divisor_zero=0 → D_LOAD.
  - div_start=1 and divisor_zero=1 → EXC.
  - Both starts high: mult_start has priority; div_start is dropped.
- M_LOAD / D_LOAD: one cycle. Asserts the matching load strobe, clears the counter, next state is M_RUN / D_RUN.
- M_RUN / D_RUN: asserts the matching step strobe every cycle and increments the counter. Leaves for WRITE after exactly MULT_CYCLES / DIV_CYCLES step cycles, i.e. the last step is at counter = N-1.
- WRITE: one cycle. Asserts HI_write=1, LO_write=1 and done=1, then returns to IDLE.
- EXC: one cycle. Asserts div0_exc=1; HI_write, LO_write and done stay 0. Returns to IDLE.
- HiLoSrc is set on entry to M_LOAD (0) or D_LOAD (1) and held until the next operation starts; it is 0 after reset.
- busy is 1 in every state except IDLE.
- Latency: with the start pulse sampled at edge t, the load strobe is asserted in cycle t+1. Steps occupy cycles t+2 through t+N+1. WRITE is cycle t+N+2, so busy lasts N+2 cycles.
- Start pulses that arrive while busy=1 are ignored; there is no queuing.
- Reset in any state, including RUN: returns to IDLE next edge with no HI/LO write and no done pulse.
- Load and step strobes are never asserted in the same cycle, and never for both units at once.

Optional Feature:
- Macro MULDIV_BUSY_CNT_EN.
- When defined: adds output busy_cycles, 32 bits.
  - Increments on every cycle with busy=1 and wraps from 0xFFFFFFFF to 0.
  - Cleared by reset; readable at any time for performance monitoring.
- When undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package muldiv_pkg holds:
  - the state encoding: 3-bit localparams ST_IDLE..ST_EXC;
  - the HiLoSrc encodings: HILO_MULT=0, HILO_DIV=1;
  - the default cycle counts.
- No sub-module is needed. The counter is a plain register inside the block, and the optional busy counter is a simple always block guarded by the macro.

Test Plan:
- Reset, then mult_start pulse at cycle 0 (N=32):
  - mult_load=1 at cycle 1; mult_step=1 for cycles 2..33;
  - HI_write=LO_write=done=1 at cycle 34, HiLoSrc=0; busy=1 for cycles 1..34.
- div_start with divisor_zero=0:
  - div_load at cycle 1; 32 div_step cycles; write at cycle 34 with HiLoSrc=1.
- div_start with divisor_zero=1:
  - div0_exc=1 only in cycle 1, busy=1 only in cycle 1;
  - no div_load, no div_step, no HI_write, no done.
- mult_start and div_start in the same cycle:
  - multiply sequence runs with HiLoSrc=0; no div strobe appears.
- Start pulses while busy:
  - mult_start at cycle 10 during a divide is ignored; the divide completes at cycle 34, then busy=0.
- reset=1 at cycle 15 of a multiply:
  - IDLE at cycle 16 with all outputs 0;
  - no write at cycle 34;
  - with MULDIV_BUSY_CNT_EN defined, busy_cycles reads 0 after reset and 34 after a full multiply.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants for the multiply/divide sequencer:
// state encoding, HI/LO source select codes and default step counts.
package muldiv_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_M_LOAD = 3'd1;
    localparam logic [2:0] ST_M_RUN  = 3'd2;
    localparam logic [2:0] ST_D_LOAD = 3'd3;
    localparam logic [2:0] ST_D_RUN  = 3'd4;
    localparam logic [2:0] ST_WRITE  = 3'd5;
    localparam logic [2:0] ST_EXC    = 3'd6;

    localparam logic HILO_MULT = 1'b0;
    localparam logic HILO_DIV  = 1'b1;

    localparam int MULT_CYCLES_DEF = 32;
    localparam int DIV_CYCLES_DEF  = 32;
    localparam int CNT_W_DEF       = 6;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Start/strobe bundle between the control FSM (master)
// and the multiply/divide sequencer (slave).
interface muldiv_sequencer_if;

    logic mult_start;
    logic div_start;
    logic divisor_zero;
    logic mult_load;
    logic mult_step;
    logic div_load;
    logic div_step;
    logic HiLoSrc;
    logic HI_write;
    logic LO_write;
    logic busy;
    logic done;
    logic div0_exc;

    modport master (
        output mult_start, div_start, divisor_zero,
        input  mult_load, mult_step, div_load, div_step,
        input  HiLoSrc, HI_write, LO_write,
        input  busy, done, div0_exc
    );

    modport slave (
        input  mult_start, div_start, divisor_zero,
        output mult_load, mult_step, div_load, div_step,
        output HiLoSrc, HI_write, LO_write,
        output busy, done, div0_exc
    );

endinterface

// File: rtl/muldiv_sequencer.sv
// Sequences the iterative multiplier/divider feeding HI/LO.
// Optional macro MULDIV_BUSY_CNT_EN adds the busy_cycles perf counter.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    muldiv_sequencer_if.slave bus
`ifdef MULDIV_BUSY_CNT_EN
    ,
    output logic [31:0] busy_cycles
`endif
);

    localparam logic [CNT_W-1:0] M_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DIV_CYCLES - 1);

    logic [2:0]       r_state;
    logic [2:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hilosrc;
    logic             w_busy;

    // Next-state selection; mult_start wins over div_start
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.mult_start)
                    w_next = ST_M_LOAD;
                else if (bus.div_start)
                    w_next = bus.divisor_zero ? ST_EXC : ST_D_LOAD;
            end
            ST_M_LOAD: w_next = ST_M_RUN;
            ST_M_RUN:  if (r_cnt == M_LAST) w_next = ST_WRITE;
            ST_D_LOAD: w_next = ST_D_RUN;
            ST_D_RUN:  if (r_cnt == D_LAST) w_next = ST_WRITE;
            ST_WRITE:  w_next = ST_IDLE;
            ST_EXC:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    // Iteration counter: cleared in LOAD, counts steps in RUN
    always_ff @(posedge clk) begin
        if (reset)
            r_cnt <= '0;
        else if (r_state == ST_M_LOAD || r_state == ST_D_LOAD)
            r_cnt <= '0;
        else if (r_state == ST_M_RUN || r_state == ST_D_RUN)
            r_cnt <= r_cnt + 1'b1;
    end

    // HI/LO source follows the unit of the last accepted operation
    always_ff @(posedge clk) begin
        if (reset)
            r_hilosrc <= HILO_MULT;
        else if (r_state == ST_IDLE && bus.mult_start)
            r_hilosrc <= HILO_MULT;
        else if (r_state == ST_IDLE && bus.div_start && !bus.divisor_zero)
            r_hilosrc <= HILO_DIV;
    end

    assign w_busy        = (r_state != ST_IDLE);
    assign bus.busy      = w_busy;
    assign bus.mult_load = (r_state == ST_M_LOAD);
    assign bus.mult_step = (r_state == ST_M_RUN);
    assign bus.div_load  = (r_state == ST_D_LOAD);
    assign bus.div_step  = (r_state == ST_D_RUN);
    assign bus.HI_write  = (r_state == ST_WRITE);
    assign bus.LO_write  = (r_state == ST_WRITE);
    assign bus.done      = (r_state == ST_WRITE);
    assign bus.div0_exc  = (r_state == ST_EXC);
    assign bus.HiLoSrc   = r_hilosrc;

`ifdef MULDIV_BUSY_CNT_EN
    logic [31:0] r_busy_cycles;

    // Free-running count of busy cycles, wraps naturally
    always_ff @(posedge clk) begin
        if (reset)
            r_busy_cycles <= '0;
        else if (w_busy)
            r_busy_cycles <= r_busy_cycles + 32'd1;
    end

    assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: timeline model plus
// directed operations with hand-computed cycle expectations.
module tb_muldiv_sequencer;

    localparam int NM = 32;
    localparam int ND = 32;

    logic clk;
    logic reset;
    muldiv_sequencer_if bus ();
`ifdef MULDIV_BUSY_CNT_EN
    logic [31:0] busy_cycles;
`endif

    muldiv_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus.slave)
`ifdef MULDIV_BUSY_CNT_EN
        ,
        .busy_cycles (busy_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: op kind and cycle index since the start edge
    bit          m_act = 1'b0;
    int          m_op  = 0;
    int          m_k   = 0;
    int          m_len = 0;
    logic        m_src = 1'b0;
    logic [31:0] m_bc  = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_act = 1'b0;
            m_k   = 0;
            m_src = 1'b0;
            m_bc  = '0;
        end else if (m_act) begin
            m_bc = m_bc + 32'd1;
            m_k++;
            if (m_k > m_len) m_act = 1'b0;
        end else if (bus.mult_start) begin
            m_act = 1'b1; m_op = 0; m_k = 1; m_len = NM + 2; m_src = 1'b0;
        end else if (bus.div_start && bus.divisor_zero) begin
            m_act = 1'b1; m_op = 2; m_k = 1; m_len = 1;
        end else if (bus.div_start) begin
            m_act = 1'b1; m_op = 1; m_k = 1; m_len = ND + 2; m_src = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(bus.busy), 32'(m_act));
            chk("mult_load", 32'(bus.mult_load),
                32'(m_act && m_op == 0 && m_k == 1));
            chk("mult_step", 32'(bus.mult_step),
                32'(m_act && m_op == 0 && m_k >= 2 && m_k <= NM + 1));
            chk("div_load", 32'(bus.div_load),
                32'(m_act && m_op == 1 && m_k == 1));
            chk("div_step", 32'(bus.div_step),
                32'(m_act && m_op == 1 && m_k >= 2 && m_k <= ND + 1));
            chk("HI_write", 32'(bus.HI_write),
                32'(m_act && m_op != 2 && m_k == m_len));
            chk("LO_write", 32'(bus.LO_write),
                32'(m_act && m_op != 2 && m_k == m_len));
            chk("done", 32'(bus.done),
                32'(m_act && m_op != 2 && m_k == m_len));
            chk("div0_exc", 32'(bus.div0_exc), 32'(m_act && m_op == 2));
            chk("HiLoSrc", 32'(bus.HiLoSrc), 32'(m_src));
`ifdef MULDIV_BUSY_CNT_EN
            chk("busy_cycles", busy_cycles, m_bc);
`endif
        end
    end

    typedef struct {
        int   ld_cyc;
        int   nld;
        int   nst;
        int   wr_cyc;
        int   nwr;
        int   nbz;
        int   nexc;
        int   nx;
        logic src;
    } res_t;

    task automatic run_op(input logic ms, input logic ds, input logic dz,
                          input int inj, input int rcy, output res_t r);
        logic own_ld, own_st, oth;
        r = '{ld_cyc: -1, nld: 0, nst: 0, wr_cyc: -1, nwr: 0,
              nbz: 0, nexc: 0, nx: 0, src: 1'bx};
        @(negedge clk);
        bus.mult_start   = ms;
        bus.div_start    = ds;
        bus.divisor_zero = dz;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.mult_start   = 1'b0;
                bus.div_start    = 1'b0;
                bus.divisor_zero = 1'b0;
            end
            own_ld = ms ? bus.mult_load : bus.div_load;
            own_st = ms ? bus.mult_step : bus.div_step;
            oth    = ms ? (bus.div_load | bus.div_step)
                        : (bus.mult_load | bus.mult_step);
            if (own_ld) begin
                r.nld++;
                if (r.ld_cyc < 0) r.ld_cyc = c;
            end
            if (own_st) r.nst++;
            if (oth) r.nx++;
            if (bus.HI_write | bus.LO_write | bus.done) begin
                r.nwr++;
                r.wr_cyc = c;
                r.src = bus.HiLoSrc;
            end
            if (bus.busy) r.nbz++;
            if (bus.div0_exc) r.nexc++;
            if (c == inj) bus.mult_start = 1'b1;
            if (c == inj + 1) bus.mult_start = 1'b0;
            if (c == rcy) reset = 1'b1;
            if (c == rcy + 1) reset = 1'b0;
        end
    endtask

    res_t r;

    initial begin
        reset            = 1'b1;
        bus.mult_start   = 1'b0;
        bus.div_start    = 1'b0;
        bus.divisor_zero = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_src", 32'(bus.HiLoSrc), 32'd0);
`ifdef MULDIV_BUSY_CNT_EN
        chk("rst_bcnt", busy_cycles, 32'd0);
`endif

        // Plain multiply
        run_op(1'b1, 1'b0, 1'b0, -5, -5, r);
        chk("mul_ld_cyc", r.ld_cyc, 1);
        chk("mul_nld", r.nld, 1);
        chk("mul_nstep", r.nst, 32);
        chk("mul_wr_cyc", r.wr_cyc, 34);
        chk("mul_nwr", r.nwr, 1);
        chk("mul_src", 32'(r.src), 32'd0);
        chk("mul_nbusy", r.nbz, 34);
        chk("mul_other", r.nx, 0);
`ifdef MULDIV_BUSY_CNT_EN
        chk("mul_bcnt", busy_cycles, 32'd34);
`endif

        // Divide, nonzero divisor
        run_op(1'b0, 1'b1, 1'b0, -5, -5, r);
        chk("div_ld_cyc", r.ld_cyc, 1);
        chk("div_nstep", r.nst, 32);
        chk("div_wr_cyc", r.wr_cyc, 34);
        chk("div_src", 32'(r.src), 32'd1);
        chk("div_nbusy", r.nbz, 34);
        chk("div_other", r.nx, 0);

        // Divide by zero
        run_op(1'b0, 1'b1, 1'b1, -5, -5, r);
        chk("dz_nld", r.nld, 0);
        chk("dz_nstep", r.nst, 0);
        chk("dz_nwr", r.nwr, 0);
        chk("dz_nbusy", r.nbz, 1);
        chk("dz_nexc", r.nexc, 1);
        chk("dz_src_hold", 32'(bus.HiLoSrc), 32'd1);

        // Both starts: multiply wins
        run_op(1'b1, 1'b1, 1'b0, -5, -5, r);
        chk("both_nstep", r.nst, 32);
        chk("both_src", 32'(r.src), 32'd0);
        chk("both_other", r.nx, 0);
        chk("both_wr_cyc", r.wr_cyc, 34);

        // Start while busy is ignored
        run_op(1'b0, 1'b1, 1'b0, 10, -5, r);
        chk("inj_wr_cyc", r.wr_cyc, 34);
        chk("inj_nbusy", r.nbz, 34);
        chk("inj_other", r.nx, 0);
        chk("inj_idle", 32'(bus.busy), 32'd0);

        // Reset in the middle of a multiply
        run_op(1'b1, 1'b0, 1'b0, -5, 15, r);
        chk("rst_nstep", r.nst, 14);
        chk("rst_nbusy", r.nbz, 15);
        chk("rst_nwr", r.nwr, 0);
        chk("rst_src_clr", 32'(bus.HiLoSrc), 32'd0);
`ifdef MULDIV_BUSY_CNT_EN
        chk("rst_bcnt_clr", busy_cycles, 32'd0);
`endif

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
